multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM for the MIPS-subset datapath. Sequences each instruction through
//  IDLE/FETCH/DECODE/EXEC/MEM/WB using a shared instruction/data memory with a req/ready
//  handshake. Drives the same control bundle as the single-cycle decoder, plus PC/IR strobes.
//  Sits between the instruction register (cmd) and the PC/IR/RegFile/ALU/memory datapath.
// PARAMETERS
//  TIMEOUT  16  max cycles waiting for mem_ready in FETCH/MEM; 0 = no timeout
// PORTS
//  clk       in   1   rising-edge clock
//  rst_n     in   1   async active-low reset
//  cmd       in   32  current IR contents (valid from DECODE onward)
//  zero      in   1   ALU zero flag (beq compare)
//  mem_ready in   1   memory done; sampled only while mem_req=1
//  mem_req   out  1   memory access request
//  IorD      out  1   0 = addr from PC, 1 = addr from ALU result
//  PCWrite   out  1   PC load strobe (one cycle)
//  IRWrite   out  1   IR load strobe (one cycle)
//  Jump, Branch, MemWrite, RegWrite  out 1 each
//  RegDst    out  2   00 rt, 01 rd, 10 $31
//  ALUSrc    out  2   00 reg B, 01 extended imm
//  RegSrc    out  2   00 ALU, 01 mem data, 10 PC+4
//  Extop     out  2   00 zero-ext, 01 sign-ext, 10 upper (imm<<16)
//  ALUCtrl   out  4   0000 pass-A, 0011 ADDU, 0100 SUBU, 0101 OR, 0110 LUI
//  state     out  3   IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=7
//  bus_err   out  1   sticky: memory timeout
//  illegal   out  1   sticky: illegal opcode (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state=IDLE, wait counter=0, bus_err=illegal=0, all control outputs 0.
//  - Outputs are combinational from state + cmd. Every output not listed for a state is 0.
//  - IDLE: exactly one cycle after reset release, then FETCH.
//  - FETCH: mem_req=1, IorD=0. On mem_ready: IRWrite=1 and PCWrite=1 (PC+4) in that cycle,
//    then DECODE. Otherwise remain in FETCH.
//  - DECODE: j(02): Jump=1, PCWrite=1, then FETCH.
//    jal(03): Jump, PCWrite, RegWrite, RegDst=10, RegSrc=10, then FETCH.
//    jr(op 0, funct 08): Jump=1, PCWrite=1, ALUCtrl=0000, then FETCH.
//    addu(21), subu(23), ori(0D), lui(0F), lw(23), sw(2B), beq(04): go to EXEC.
//    Anything else is illegal.
//  - ALU controls are held constant in EXEC, MEM and WB for the decoded op:
//    addu: RegDst=01, ALUCtrl=0011.  subu: RegDst=01, ALUCtrl=0100.
//    ori:  ALUSrc=01, Extop=00, ALUCtrl=0101.  lui: ALUSrc=01, Extop=10, ALUCtrl=0110.
//    lw/sw: ALUSrc=01, Extop=01, ALUCtrl=0011.  beq: Extop=01, ALUCtrl=0100.
//  - EXEC: beq drives Branch=1 and PCWrite=zero, then FETCH. lw/sw go to MEM.
//    addu/subu/ori/lui go to WB.
//  - MEM: mem_req=1, IorD=1, MemWrite=1 for sw for the whole state.
//    On mem_ready: sw goes to FETCH, lw goes to WB.
//  - WB: RegWrite=1 for one cycle. RegSrc=01 for lw, otherwise 00. Then FETCH.
//  - Timeout: the counter counts cycles with mem_req=1 && !mem_ready and clears when the
//    state changes. When count == TIMEOUT (and TIMEOUT != 0): bus_err<=1, state<=HALT.
//    mem_ready arriving in that same cycle wins (no error).
//  - HALT: all control outputs 0, mem_req=0. Only rst_n exits HALT.
//  - Reset asserted mid-access: state drops to IDLE immediately. mem_req and all strobes
//    drop asynchronously; the aborted instruction has no side effects.
//  - CPI: j/jal/jr=2, beq=3, R/ori/lui=4, sw=4, lw=5 (zero-wait memory, ready in 1st cycle).
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:   illegal opcode in DECODE sets illegal<=1 and goes to HALT.
//  ILLEGAL_TRAP_EN undefined: illegal opcode is a NOP (DECODE goes to FETCH, no strobes);
//    illegal is tied 0.
// TESTING
//  1. Reset, ready always 1, cmd=addu $3,$1,$2 (0x00221821) -> states 0,1,2,3,5,1;
//     RegWrite=1 only in WB with RegDst=01, ALUCtrl=0011.
//  2. lw 0x8C220004 with ready delayed 3 cycles in FETCH and 2 in MEM -> FETCH held 4 cycles,
//     MEM held 3; IRWrite/PCWrite one pulse; WB RegSrc=01.
//  3. beq 0x10220003: zero=1 -> PCWrite=1 and Branch=1 in EXEC; zero=0 -> PCWrite stays 0;
//     both return to FETCH.
//  4. TIMEOUT=4, mem_ready held 0 in MEM on sw -> after 4 wait cycles bus_err=1, state=7,
//     MemWrite=0; stays in HALT until rst_n pulse.
//  5. cmd=0xFC000000: with ILLEGAL_TRAP_EN -> illegal=1, HALT; without -> DECODE to FETCH,
//     no RegWrite/MemWrite.
//  6. rst_n low in MEM of sw with ready=0 -> mem_req/MemWrite low same cycle (async);
//     after release, IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control FSM for the MIPS-subset datapath: IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT.
// Optional feature: define ILLEGAL_TRAP_EN to trap illegal opcodes into HALT (default: NOP).
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cmd,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IorD,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        Jump,
  output logic        Branch,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  ALUSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  Extop,
  output logic [3:0]  ALUCtrl,
  output logic [2:0]  state,
  output logic        bus_err,
  output logic        illegal
);

  // Handshake: mem_req is held high for the whole FETCH/MEM state; mem_ready is only
  // meaningful while mem_req=1, and the access completes in the cycle it is seen high.

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0011;
  localparam logic [3:0] ALU_SUBU = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          bus_err_q, bus_err_d;

  logic [5:0] op;
  logic [5:0] funct;
  logic       is_rtype;
  logic       is_addu, is_subu, is_jr;
  logic       is_j, is_jal, is_beq, is_ori, is_lui, is_lw, is_sw;
  logic       is_jump_op, is_exec_op, is_illegal;
  logic       wait_stall, timeout_hit;
  logic       unused_cmd_bits;

  assign op              = cmd[31:26];
  assign funct           = cmd[5:0];
  assign unused_cmd_bits = ^cmd[25:6];

  assign is_rtype = (op == OP_RTYPE);
  assign is_addu  = is_rtype && (funct == FN_ADDU);
  assign is_subu  = is_rtype && (funct == FN_SUBU);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_beq   = (op == OP_BEQ);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);

  assign is_jump_op = is_j || is_jal || is_jr;
  assign is_exec_op = is_addu || is_subu || is_ori || is_lui || is_lw || is_sw || is_beq;
  assign is_illegal = !(is_jump_op || is_exec_op);

  // A timeout only fires when the access is still stalled; a late mem_ready wins.
  assign wait_stall  = mem_req && !mem_ready;
  assign timeout_hit = (TIMEOUT != 0) && wait_stall && (wait_q == TO_VAL);

  // ALU-side controls shared by EXEC, MEM and WB for the decoded instruction.
  logic [1:0] op_regdst;
  logic [1:0] op_alusrc;
  logic [1:0] op_extop;
  logic [3:0] op_aluctrl;

  always_comb begin
    op_regdst  = 2'b00;
    op_alusrc  = 2'b00;
    op_extop   = 2'b00;
    op_aluctrl = ALU_PASS;
    if (is_addu) begin
      op_regdst  = 2'b01;
      op_aluctrl = ALU_ADDU;
    end else if (is_subu) begin
      op_regdst  = 2'b01;
      op_aluctrl = ALU_SUBU;
    end else if (is_ori) begin
      op_alusrc  = 2'b01;
      op_extop   = 2'b00;
      op_aluctrl = ALU_OR;
    end else if (is_lui) begin
      op_alusrc  = 2'b01;
      op_extop   = 2'b10;
      op_aluctrl = ALU_LUI;
    end else if (is_lw || is_sw) begin
      op_alusrc  = 2'b01;
      op_extop   = 2'b01;
      op_aluctrl = ALU_ADDU;
    end else if (is_beq) begin
      op_extop   = 2'b01;
      op_aluctrl = ALU_SUBU;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_DECODE: begin
        if (is_jump_op)      state_d = S_FETCH;
        else if (is_exec_op) state_d = S_EXEC;
        else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        if (is_beq)              state_d = S_FETCH;
        else if (is_lw || is_sw) state_d = S_MEM;
        else                     state_d = S_WB;
      end
      S_MEM: begin
        if (mem_ready)        state_d = is_sw ? S_FETCH : S_WB;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // The wait counter restarts on every state change and saturates at TIMEOUT.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if (wait_stall && (wait_q != TO_VAL))
      wait_d = wait_q + 1'b1;
  end

  assign bus_err_d = bus_err_q || timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q || ((state_q == S_DECODE) && is_illegal);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Outputs are decoded from the registered state, so reset clears them asynchronously.
  always_comb begin
    mem_req  = 1'b0;
    IorD     = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    Jump     = 1'b0;
    Branch   = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 2'b00;
    ALUSrc   = 2'b00;
    RegSrc   = 2'b00;
    Extop    = 2'b00;
    ALUCtrl  = ALU_PASS;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_j) begin
          Jump    = 1'b1;
          PCWrite = 1'b1;
        end else if (is_jal) begin
          Jump     = 1'b1;
          PCWrite  = 1'b1;
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          RegSrc   = 2'b10;
        end else if (is_jr) begin
          Jump    = 1'b1;
          PCWrite = 1'b1;
          ALUCtrl = ALU_PASS;
        end
      end
      S_EXEC: begin
        RegDst  = op_regdst;
        ALUSrc  = op_alusrc;
        Extop   = op_extop;
        ALUCtrl = op_aluctrl;
        if (is_beq) begin
          Branch  = 1'b1;
          PCWrite = zero;
        end
      end
      S_MEM: begin
        RegDst   = op_regdst;
        ALUSrc   = op_alusrc;
        Extop    = op_extop;
        ALUCtrl  = op_aluctrl;
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = is_sw;
      end
      S_WB: begin
        RegDst   = op_regdst;
        ALUSrc   = op_alusrc;
        Extop    = op_extop;
        ALUCtrl  = op_aluctrl;
        RegWrite = 1'b1;
        RegSrc   = is_lw ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm (TIMEOUT=4); honours ILLEGAL_TRAP_EN if defined.
module tb_multicycle_ctrl_fsm;

  localparam int W = 25;

  logic        clk;
  logic        rst_n;
  logic [31:0] cmd;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, IorD, PCWrite, IRWrite, Jump, Branch, MemWrite, RegWrite;
  logic [1:0]  RegDst, ALUSrc, RegSrc, Extop;
  logic [3:0]  ALUCtrl;
  logic [2:0]  state;
  logic        bus_err, illegal;

  multicycle_ctrl_fsm #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .Jump(Jump), .Branch(Branch), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .RegSrc(RegSrc), .Extop(Extop),
    .ALUCtrl(ALUCtrl), .state(state), .bus_err(bus_err), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobes packed as {mem_req, IorD, PCWrite, IRWrite, Jump, Branch, MemWrite, RegWrite}
  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_FWAIT = 8'b1000_0000;
  localparam logic [7:0] S_FDONE = 8'b1011_0000;
  localparam logic [7:0] S_JMP   = 8'b0010_1000;
  localparam logic [7:0] S_JAL   = 8'b0010_1001;
  localparam logic [7:0] S_BR_T  = 8'b0010_0100;
  localparam logic [7:0] S_BR_N  = 8'b0000_0100;
  localparam logic [7:0] S_MRD   = 8'b1100_0000;
  localparam logic [7:0] S_MWR   = 8'b1100_0010;
  localparam logic [7:0] S_WB    = 8'b0000_0001;

  // ALU bundle packed as {RegDst, ALUSrc, Extop, ALUCtrl}
  localparam logic [9:0] A_NONE = 10'b00_00_00_0000;
  localparam logic [9:0] A_ADDU = 10'b01_00_00_0011;
  localparam logic [9:0] A_SUBU = 10'b01_00_00_0100;
  localparam logic [9:0] A_ORI  = 10'b00_01_00_0101;
  localparam logic [9:0] A_LUI  = 10'b00_01_10_0110;
  localparam logic [9:0] A_LSW  = 10'b00_01_01_0011;
  localparam logic [9:0] A_BEQ  = 10'b00_00_01_0100;
  localparam logic [9:0] A_JAL  = 10'b10_00_00_0000;

  localparam logic [31:0] I_ADDU = 32'h0022_1821;
  localparam logic [31:0] I_SUBU = 32'h0022_1823;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0008;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_ORI  = 32'h3422_0005;
  localparam logic [31:0] I_LUI  = 32'h3C01_0012;
  localparam logic [31:0] I_J    = 32'h0800_0010;
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_JR   = 32'h03E0_0008;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;

  logic [W-1:0] exp_q[$];
  int check_cnt = 0;
  int err_cnt   = 0;

  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [7:0] strb,
                                      input logic [1:0] rsrc, input logic [9:0] alu,
                                      input logic berr, input logic ill);
    return {st, strb, alu[9:8], alu[7:6], rsrc, alu[5:4], alu[3:0], berr, ill};
  endfunction

  function automatic logic [W-1:0] observed();
    return {state, mem_req, IorD, PCWrite, IRWrite, Jump, Branch, MemWrite, RegWrite,
            RegDst, ALUSrc, RegSrc, Extop, ALUCtrl, bus_err, illegal};
  endfunction

  // Pops the oldest expectation and compares it with the DUT outputs right now.
  task automatic check(input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    check_cnt++;
    if (exp_q.size() == 0) begin
      err_cnt++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, observed());
    end else begin
      exp_v = exp_q.pop_front();
      obs_v = observed();
      assert (obs_v === exp_v) else begin
        err_cnt++;
        $error("FAIL %s: observed %h expected %h", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [W-1:0] exp_v);
    exp_q.push_back(exp_v);
    #1;
    check(tag);
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then advance.
  task automatic step(input string tag, input logic rdy, input logic z, input logic [W-1:0] exp_v);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(exp_v);
    #1;
    check(tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input string tag, input logic [31:0] c);
    cmd = c;
    step(tag, 1'b1, 1'b0, mk(3'd1, S_FDONE, 2'b00, A_NONE, 1'b0, 1'b0));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd       = 32'h0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #2;
    check_now("reset", mk(3'd0, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 1'b1, 1'b0, mk(3'd0, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));

    // addu with zero-wait memory: FETCH, DECODE, EXEC, WB
    fetch("addu_fetch", I_ADDU);
    step("addu_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("addu_exec",   1'b1, 1'b0, mk(3'd3, S_NONE, 2'b00, A_ADDU, 1'b0, 1'b0));
    step("addu_wb",     1'b1, 1'b0, mk(3'd5, S_WB,   2'b00, A_ADDU, 1'b0, 1'b0));

    // lw with 3 wait cycles in FETCH and 2 in MEM
    cmd = I_LW;
    for (int i = 0; i < 3; i++)
      step("lw_fetch_wait", 1'b0, 1'b0, mk(3'd1, S_FWAIT, 2'b00, A_NONE, 1'b0, 1'b0));
    fetch("lw_fetch_done", I_LW);
    step("lw_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("lw_exec",   1'b1, 1'b0, mk(3'd3, S_NONE, 2'b00, A_LSW,  1'b0, 1'b0));
    for (int i = 0; i < 2; i++)
      step("lw_mem_wait", 1'b0, 1'b0, mk(3'd4, S_MRD, 2'b00, A_LSW, 1'b0, 1'b0));
    step("lw_mem_done", 1'b1, 1'b0, mk(3'd4, S_MRD, 2'b00, A_LSW, 1'b0, 1'b0));
    step("lw_wb",       1'b1, 1'b0, mk(3'd5, S_WB,  2'b01, A_LSW, 1'b0, 1'b0));

    // beq taken and not taken
    fetch("beq_t_fetch", I_BEQ);
    step("beq_t_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("beq_t_exec",   1'b1, 1'b1, mk(3'd3, S_BR_T, 2'b00, A_BEQ,  1'b0, 1'b0));
    fetch("beq_n_fetch", I_BEQ);
    step("beq_n_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("beq_n_exec",   1'b1, 1'b0, mk(3'd3, S_BR_N, 2'b00, A_BEQ,  1'b0, 1'b0));

    // jumps complete in DECODE
    fetch("j_fetch", I_J);
    step("j_decode",   1'b1, 1'b0, mk(3'd2, S_JMP, 2'b00, A_NONE, 1'b0, 1'b0));
    fetch("jal_fetch", I_JAL);
    step("jal_decode", 1'b1, 1'b0, mk(3'd2, S_JAL, 2'b10, A_JAL,  1'b0, 1'b0));
    fetch("jr_fetch", I_JR);
    step("jr_decode",  1'b1, 1'b0, mk(3'd2, S_JMP, 2'b00, A_NONE, 1'b0, 1'b0));

    // immediate and subtract ops through WB
    fetch("ori_fetch", I_ORI);
    step("ori_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("ori_exec",   1'b1, 1'b0, mk(3'd3, S_NONE, 2'b00, A_ORI,  1'b0, 1'b0));
    step("ori_wb",     1'b1, 1'b0, mk(3'd5, S_WB,   2'b00, A_ORI,  1'b0, 1'b0));
    fetch("lui_fetch", I_LUI);
    step("lui_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("lui_exec",   1'b1, 1'b0, mk(3'd3, S_NONE, 2'b00, A_LUI,  1'b0, 1'b0));
    step("lui_wb",     1'b1, 1'b0, mk(3'd5, S_WB,   2'b00, A_LUI,  1'b0, 1'b0));
    fetch("subu_fetch", I_SUBU);
    step("subu_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("subu_exec",   1'b1, 1'b0, mk(3'd3, S_NONE, 2'b00, A_SUBU, 1'b0, 1'b0));
    step("subu_wb",     1'b1, 1'b0, mk(3'd5, S_WB,   2'b00, A_SUBU, 1'b0, 1'b0));

    // reset asserted mid-MEM of a stalled sw drops everything asynchronously
    fetch("sw_fetch", I_SW);
    step("sw_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("sw_exec",   1'b1, 1'b0, mk(3'd3, S_NONE, 2'b00, A_LSW,  1'b0, 1'b0));
    mem_ready = 1'b0;
    check_now("sw_mem_before_rst", mk(3'd4, S_MWR, 2'b00, A_LSW, 1'b0, 1'b0));
    #2;
    rst_n = 1'b0;
    check_now("rst_async", mk(3'd0, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_after_rst", 1'b1, 1'b0, mk(3'd0, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));

    // sw with memory that never answers: 4 counted waits, then HALT on the 5th cycle
    fetch("to_fetch", I_SW);
    step("to_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    step("to_exec",   1'b1, 1'b0, mk(3'd3, S_NONE, 2'b00, A_LSW,  1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      step("to_mem_wait", 1'b0, 1'b0, mk(3'd4, S_MWR, 2'b00, A_LSW, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++)
      step("halt_hold", 1'b1, 1'b1, mk(3'd7, S_NONE, 2'b00, A_NONE, 1'b1, 1'b0));
    rst_n = 1'b0;
    check_now("halt_rst", mk(3'd0, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    step("idle_after_halt", 1'b1, 1'b0, mk(3'd0, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));

    // illegal opcode
    fetch("ill_fetch", I_ILL);
    step("ill_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 2; i++)
      step("ill_halt", 1'b1, 1'b0, mk(3'd7, S_NONE, 2'b00, A_NONE, 1'b0, 1'b1));
`else
    fetch("ill_nop_fetch", I_ADDU);
    step("ill_nop_decode", 1'b1, 1'b0, mk(3'd2, S_NONE, 2'b00, A_NONE, 1'b0, 1'b0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
